// File: rtl/cavlc_dec_pkg.sv
// rtl/cavlc_dec_pkg.sv - shared types, constants and helpers for the CAVLC level decoder
package cavlc_dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_T1,
    ST_LEVEL,
    ST_FLUSH
  } state_t;

  localparam int SUFFIX_ESC       = 12;
  localparam int PREFIX_ESC       = 15;
  localparam int PREFIX_14_SUFFIX = 4;
  localparam int SL_MAX           = 6;

  // |level| above this grows suffixLength; sl is always >= 1 here
  function automatic logic [16:0] level_thresh(input logic [2:0] sl);
    return 17'd3 << (sl - 3'd1);
  endfunction

endpackage

// File: rtl/cavlc_lzc.sv
// rtl/cavlc_lzc.sv - leading-zero counter over 16 bits; 16 means the input is all zero
module cavlc_lzc (
  input  logic [15:0] i_bits,
  output logic [4:0]  o_count
);

  always_comb begin
    o_count = 5'd16;
    for (int i = 0; i < 16; i++) begin
      if (i_bits[i]) o_count = 5'(15 - i);
    end
  end

endmodule

// File: rtl/cavlc_level_dec.sv
// rtl/cavlc_level_dec.sv - CAVLC level decoder: trailing-one signs, then prefix/suffix levels
module cavlc_level_dec
  import cavlc_dec_pkg::*;
#(
  parameter int RES_WIDTH = 16,
  parameter int WIN_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4:0]           total_coeff,
  input  logic [1:0]           trailing_ones,
  input  logic [WIN_WIDTH-1:0] bits_win,
  input  logic                 bits_valid,
  output logic                 bits_used_en,
  output logic [4:0]           bits_used,
  output logic [RES_WIDTH-1:0] level_out,
  output logic [3:0]           level_idx,
  output logic                 level_valid,
  input  logic                 level_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int SAT_MAX_I = (RES_WIDTH >= 17) ? 65535 : (1 << (RES_WIDTH - 1)) - 1;
  localparam logic signed [16:0] SAT_MAX = 17'(SAT_MAX_I);
  localparam logic signed [16:0] SAT_MIN = 17'(-SAT_MAX_I - 1);

  state_t                r_state;
  logic [4:0]            r_cnt;
  logic [4:0]            r_total;
  logic [1:0]            r_t1;
  logic [2:0]            r_sl;

  logic [4:0]            w_prefix;
  logic                  w_adv;
  logic                  w_err;
  logic                  w_esc;
  logic                  w_first;
  logic [3:0]            w_suf_size;
  logic [11:0]           w_suf_raw;
  logic [11:0]           w_suffix;
  logic [16:0]           w_code;
  logic [16:0]           w_mag;
  logic signed [16:0]    w_level;
  logic signed [16:0]    w_clamped;
  logic [2:0]            w_sl_base;
  logic [2:0]            w_sl_next;
  logic [4:0]            w_cnt_inc;

  cavlc_lzc u_lzc (
    .i_bits  (bits_win[WIN_WIDTH-1 -: 16]),
    .o_count (w_prefix)
  );

  assign w_adv = (r_state == ST_T1 || r_state == ST_LEVEL) && bits_valid &&
                 (!level_valid || level_ready);
  assign w_err = (r_state == ST_LEVEL) && w_adv && (w_prefix > 5'(PREFIX_ESC));
  assign w_esc = (w_prefix == 5'(PREFIX_ESC));

  always_comb begin
    if (w_esc)                                     w_suf_size = 4'(SUFFIX_ESC);
    else if (w_prefix == 5'd14 && r_sl == 3'd0)    w_suf_size = 4'(PREFIX_14_SUFFIX);
    else                                           w_suf_size = {1'b0, r_sl};
  end

  // Suffix starts right after the prefix's terminating 1; right-align then trim to its size
  assign w_suf_raw = 12'(bits_win >> (WIN_WIDTH - 13 - int'(w_prefix)));
  assign w_suffix  = w_suf_raw >> (4'(SUFFIX_ESC) - w_suf_size);

  assign w_first   = (r_cnt == {3'b0, r_t1}) && (r_t1 != 2'd3);
  assign w_code    = (17'(w_prefix[3:0]) << r_sl) + 17'(w_suffix) +
                     ((w_esc && r_sl == 3'd0) ? 17'd15 : 17'd0) +
                     (w_first ? 17'd2 : 17'd0);
  assign w_mag     = (w_code + 17'd2 - {16'd0, w_code[0]}) >> 1;
  assign w_level   = w_code[0] ? -$signed(w_mag) : $signed(w_mag);

  always_comb begin
    if (w_level > SAT_MAX)      w_clamped = SAT_MAX;
    else if (w_level < SAT_MIN) w_clamped = SAT_MIN;
    else                        w_clamped = w_level;
  end

  assign w_sl_base = (r_sl == 3'd0) ? 3'd1 : r_sl;
  assign w_sl_next = (w_mag > level_thresh(w_sl_base) && w_sl_base < 3'(SL_MAX)) ?
                     w_sl_base + 3'd1 : w_sl_base;
  assign w_cnt_inc = r_cnt + 5'd1;

  assign bits_used_en = w_adv && !w_err;
  assign bits_used    = !bits_used_en        ? 5'd0 :
                        (r_state == ST_T1)   ? 5'd1 :
                        w_prefix + 5'd1 + {1'b0, w_suf_size};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_total     <= '0;
      r_t1        <= '0;
      r_sl        <= '0;
      level_out   <= '0;
      level_idx   <= '0;
      level_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (level_valid && level_ready) level_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cnt   <= '0;
            r_total <= total_coeff;
            r_t1    <= trailing_ones;
            r_sl    <= (total_coeff > 5'd10 && trailing_ones != 2'd3) ? 3'd1 : 3'd0;
            busy    <= 1'b1;
            if (total_coeff == 5'd0)        r_state <= ST_FLUSH;
            else if (trailing_ones != 2'd0) r_state <= ST_T1;
            else                            r_state <= ST_LEVEL;
          end
        end
        ST_T1: begin
          if (w_adv) begin
            level_out   <= bits_win[WIN_WIDTH-1] ? {RES_WIDTH{1'b1}} : RES_WIDTH'(1);
            level_idx   <= r_cnt[3:0];
            level_valid <= 1'b1;
            r_cnt       <= w_cnt_inc;
            if (w_cnt_inc == r_total)             r_state <= ST_FLUSH;
            else if (w_cnt_inc == {3'b0, r_t1})   r_state <= ST_LEVEL;
          end
        end
        ST_LEVEL: begin
          if (w_err) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_adv) begin
            level_out   <= RES_WIDTH'(w_clamped);
            level_idx   <= r_cnt[3:0];
            level_valid <= 1'b1;
            r_cnt       <= w_cnt_inc;
            r_sl        <= w_sl_next;
            if (w_cnt_inc == r_total) r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // Wait for the final level to leave the output register
          if (!level_valid || level_ready) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cavlc_level_dec.sv
// tb/tb_cavlc_level_dec.sv - scoreboard bench for cavlc_level_dec with a bit-level reference model
module tb_cavlc_level_dec;

  localparam int RW = 16;
  localparam int WW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [4:0]    total_coeff = '0;
  logic [1:0]    trailing_ones = '0;
  logic [WW-1:0] bits_win = '0;
  logic          bits_valid = 1'b0;
  logic          bits_used_en;
  logic [4:0]    bits_used;
  logic [RW-1:0] level_out;
  logic [3:0]    level_idx;
  logic          level_valid;
  logic          level_ready = 1'b0;
  logic          busy;
  logic          done;
  logic          err;

  cavlc_level_dec #(.RES_WIDTH(RW), .WIN_WIDTH(WW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .total_coeff   (total_coeff),
    .trailing_ones (trailing_ones),
    .bits_win      (bits_win),
    .bits_valid    (bits_valid),
    .bits_used_en  (bits_used_en),
    .bits_used     (bits_used),
    .level_out     (level_out),
    .level_idx     (level_idx),
    .level_valid   (level_valid),
    .level_ready   (level_ready),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int done_cnt = 0, err_cnt = 0, n_blocks = 0;
  int take_n = 0, rd = 0, stall = 0;
  bit stream[$];
  int exp_len[$], exp_lvl[$], exp_idx[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with empty scoreboard", name);
  endtask

  task automatic push_bits(input int v, input int n);
    for (int i = n - 1; i >= 0; i--) stream.push_back(((v >> i) & 1) != 0);
  endtask

  task automatic expect_lvl(input int len, input int lv, input int idx);
    exp_len.push_back(len);
    exp_lvl.push_back(lv);
    exp_idx.push_back(idx);
  endtask

  // Reference model: builds a random coded block bit by bit and records what it should decode to
  task automatic gen_block(input int total, input int t1);
    int sl, p, ssz, suf, lc, lv, mag;
    bit b;
    sl = (total > 10 && t1 < 3) ? 1 : 0;
    for (int k = 0; k < total; k++) begin
      if (k < t1) begin
        b = 1'($urandom_range(0, 1));
        stream.push_back(b);
        expect_lvl(1, b ? -1 : 1, k);
      end else begin
        p   = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 5) : $urandom_range(0, 15);
        ssz = (p == 15) ? 12 : (p == 14 && sl == 0) ? 4 : sl;
        suf = (ssz == 0) ? 0 : $urandom_range(0, (1 << ssz) - 1);
        push_bits(0, p);
        push_bits(1, 1);
        push_bits(suf, ssz);
        lc = (p << sl) + suf;
        if (p == 15 && sl == 0) lc += 15;
        if (k == t1 && t1 < 3) lc += 2;
        lv = (lc % 2 == 0) ? (lc + 2) / 2 : -((lc + 1) / 2);
        expect_lvl(p + 1 + ssz, lv, k);
        if (sl == 0) sl = 1;
        mag = (lv < 0) ? -lv : lv;
        if (mag > 3 * (1 << (sl - 1)) && sl < 6) sl++;
      end
    end
  endtask

  task automatic start_block(input int tc, input int t1);
    @(posedge clk); #2;
    start = 1'b1;
    total_coeff = 5'(tc);
    trailing_ones = 2'(t1);
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic run_block(input int tc, input int t1, input bit poke);
    int target;
    target = done_cnt + 1;
    n_blocks++;
    start_block(tc, t1);
    if (poke) begin
      @(posedge clk); #2;
      start = 1'b1;
      total_coeff = 5'd3;
      trailing_ones = 2'd3;
      @(posedge clk); #2;
      start = 1'b0;
      stall = 3;
    end
    for (int c = 0; c < 2000 && done_cnt < target; c++) @(posedge clk);
    chk("block_done_timeout", int'(done_cnt >= target), 1);
  endtask

  // Window driver: applies last cycle's consume, then presents the next bits and random flow control
  initial begin
    forever begin
      @(posedge clk);
      rd += take_n;
      #1;
      for (int i = 0; i < WW; i++)
        bits_win[WW-1-i] = (rd + i < stream.size()) ? stream[rd+i] : 1'b1;
      bits_valid = ($urandom_range(0, 7) != 0);
      if (stall > 0) begin
        level_ready = 1'b0;
        stall--;
      end else begin
        level_ready = ($urandom_range(0, 4) != 0);
      end
    end
  end

  always @(negedge clk) begin
    take_n = 0;
    if (rst_n) begin
      if (bits_used_en) begin
        chk("consume_gate", int'(bits_valid && !(level_valid && !level_ready)), 1);
        if (exp_len.size() == 0) fail_now("unexpected_consume");
        else chk("bits_used", int'(bits_used), exp_len.pop_front());
        take_n = int'(bits_used);
      end
      if (level_valid) begin
        if (exp_lvl.size() == 0) fail_now("unexpected_level");
        else begin
          chk("level_out", int'($signed(level_out)), exp_lvl[0]);
          chk("level_idx", int'(level_idx), exp_idx[0]);
          if (level_ready) begin
            void'(exp_lvl.pop_front());
            void'(exp_idx.pop_front());
          end
        end
      end
      if (done) begin
        done_cnt++;
        chk("busy_at_done", int'(busy), 0);
      end
      if (err) begin
        err_cnt++;
        chk("busy_at_err", int'(busy), 0);
      end
    end
  end

  initial begin
    int tc, t1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_outputs", int'({bits_used_en, bits_used, level_out, level_idx,
                               level_valid, busy, done, err}), 0);
    rst_n = 1'b1;

    push_bits(1, 1);
    expect_lvl(1, 2, 0);
    run_block(1, 0, 1'b0);

    push_bits(2, 3);
    expect_lvl(1, 1, 0);
    expect_lvl(1, -1, 1);
    expect_lvl(1, 1, 2);
    run_block(3, 3, 1'b0);

    push_bits(3, 5);
    expect_lvl(5, -5, 0);
    for (int k = 1; k < 11; k++) begin
      push_bits(4, 3);
      expect_lvl(3, 1, k);
    end
    run_block(11, 0, 1'b0);

    push_bits(0, 14);
    push_bits(26, 5);
    expect_lvl(19, 14, 0);
    run_block(1, 0, 1'b0);

    push_bits(0, 15);
    push_bits(1, 1);
    push_bits('hABC, 12);
    expect_lvl(28, 1391, 0);
    run_block(1, 0, 1'b0);

    for (int b = 0; b < 60; b++) begin
      tc = (b % 15 == 7) ? 16 : $urandom_range(0, 16);
      t1 = $urandom_range(0, (tc < 3) ? tc : 3);
      gen_block(tc, t1);
      run_block(tc, t1, b % 15 == 7);
    end

    push_bits(0, 20);
    push_bits(0, 20);
    start_block(2, 0);
    for (int c = 0; c < 200 && err_cnt == 0; c++) @(posedge clk);
    chk("err_pulse", err_cnt, 1);

    @(negedge clk);
    stream.delete();
    rd = 0;
    gen_block(16, 0);
    start_block(16, 0);
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", int'({bits_used_en, bits_used, level_out, level_idx,
                                     level_valid, busy, done, err}), 0);
    exp_len.delete();
    exp_lvl.delete();
    exp_idx.delete();
    stream.delete();
    rd = 0;
    @(negedge clk); #1;
    rst_n = 1'b1;

    for (int b = 0; b < 10; b++) begin
      tc = $urandom_range(0, 16);
      t1 = $urandom_range(0, (tc < 3) ? tc : 3);
      gen_block(tc, t1);
      run_block(tc, t1, 1'b0);
    end

    repeat (3) @(posedge clk);
    chk("levels_drained", exp_lvl.size(), 0);
    chk("consumes_drained", exp_len.size(), 0);
    chk("err_total", err_cnt, 1);
    chk("done_total", done_cnt, n_blocks);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cavlc_level_dec.md
# cavlc_level_dec

Decodes the CAVLC level fields of one 4x4 or chroma-DC residual block from an MSB-first bitstream window: trailing-one sign bits first, then level_prefix/level_suffix pairs with adaptive suffixLength. It sits in the H.264 decoder's CAVLC path after coeff_token parsing and before total_zeros/run_before. It is the decode-side counterpart of the encoder's level coder and emits one signed level per cycle in reverse scan order (highest frequency first).

## Interface
- RES_WIDTH, 16, width of the signed output level (two's complement)
- WIN_WIDTH, 32, bitstream window width; at least 28 (15 prefix + 1 + 12 suffix)
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- start  in  1  one-cycle pulse that starts a block; honoured only in IDLE
- total_coeff  in  5  TotalCoeff, 0..16, sampled on start
- trailing_ones  in  2  TrailingOnes, 0..3, sampled on start; always <= total_coeff
- bits_win  in  WIN_WIDTH  next unconsumed bits, MSB = next bit
- bits_valid  in  1  bits_win holds at least WIN_WIDTH valid bits
- bits_used_en  out  1  combinational consume strobe for the upstream shifter
- bits_used  out  5  number of bits consumed this cycle, 1..28
- level_out  out  RES_WIDTH  decoded signed level, registered
- level_idx  out  4  level index 0..total_coeff-1, registered
- level_valid  out  1  level_out and level_idx are valid
- level_ready  in  1  downstream accepts a level when level_valid=1
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse after the last level is accepted
- err  out  1  one-cycle pulse: level_prefix > 15 or zero-padded window

## Operation
- States: IDLE, T1, LEVEL, FLUSH.
- IDLE + start:
  - total_coeff=0 -> FLUSH.
  - trailing_ones>0 -> T1.
  - otherwise -> LEVEL.
- On start: cnt <= 0; sl <= (total_coeff>10 && trailing_ones<3) ? 1 : 0.
- Advance condition: state active, bits_valid=1, and (level_valid=0 or level_ready=1).
- T1 advance: consume 1 bit; emit +1 if the bit is 0, -1 if it is 1. After trailing_ones emissions -> LEVEL, or FLUSH if cnt reaches total_coeff.
- LEVEL advance:
  - prefix = leading zeros of bits_win.
  - suffixSize = 4 if prefix==14 && sl==0; 12 if prefix==15; else sl.
  - Consume prefix+1+suffixSize bits.
  - levelCode = (min(prefix,15) << sl) + suffix.
  - Add 15 if prefix==15 && sl==0.
  - Add 2 on the first LEVEL decode when trailing_ones<3.
  - Level = (levelCode+2)>>1 if levelCode is even; -((levelCode+1)>>1) if odd.
- sl update after each LEVEL decode:
  - sl==0 -> sl=1.
  - Then, if |level| > (3 << (sl-1)) and sl<6 -> sl+1.
- Use 17-bit internal arithmetic; the output saturates to RES_WIDTH.
- When the last level is accepted (cnt == total_coeff) -> FLUSH. FLUSH pulses done and -> IDLE.
- Error: prefix>15 (window zero through bit 15) -> err pulse, no consume, no emission, -> IDLE.
- start while busy is ignored.
- Reset mid-block: state IDLE; all outputs 0; partially consumed bits are not reported.

## Timing
- Reset values: bits_used_en=0, bits_used=0, level_out=0, level_idx=0, level_valid=0, busy=0, done=0, err=0.
- start -> first bits_used_en in the next cycle, given bits_valid=1.
- The window advances in the same cycle as bits_used_en. level_valid rises in the following cycle (latency 1).
- Throughput is one level per cycle while bits_valid=1 and level_ready=1.
- level_valid=1 && level_ready=0: outputs hold and no bits are consumed.
- bits_valid=0: stall; no consume, no state change.
- done rises in the cycle after the final level handshake; busy falls with it.

## Structure
- Shared package cavlc_dec_pkg:
  - state enum
  - SUFFIX_ESC=12, PREFIX_ESC=15, PREFIX_14_SUFFIX=4, SL_MAX=6
  - level-increment threshold function (3 << (sl-1))
- Sub-module cavlc_lzc: combinational leading-zero counter over the top 16 bits of bits_win. Output is a 5-bit count, where 16 means all zero.
- Top level holds the FSM, counters, suffix extraction (barrel shift), level reconstruction and the output register.

## Test plan
- total=1, t1=0, sl=0, bits_win=1xxx… -> bits_used=1, level +2, idx 0, then done.
- total=3, t1=3, bits 010… -> three 1-bit consumes, levels +1, -1, +1 at idx 0, 1, 2, then done; no LEVEL decode.
- total=11, t1=0, initial sl=1, bits 0001_1… -> prefix 3, suffix 1, levelCode 7+2=9 -> level -5; sl becomes 2.
- prefix 14 with sl=0 (14 zeros, 1, suffix 1010) -> 19 bits used. Prefix 15 escape with 12-bit suffix -> 28 bits used, correct large level.
- Backpressure: hold level_ready=0 for 3 cycles mid-block -> level_out held, bits_used_en=0; resume matches the no-stall stream.
- bits_win all zero in LEVEL -> err pulse, busy=0. Assert rst_n mid-block -> all outputs 0 asynchronously.
